// File: rtl/amostra_feeder_if.sv
// rtl/amostra_feeder_if.sv - sample source to feeder stream handshake
`timescale 1ns/1ps
interface amostra_feeder_if #(
    parameter int IN_W = 16
);
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/amostra_feeder.sv
// rtl/amostra_feeder.sv - sample FIFO feeding pwm one offset-binary amostra per period
`timescale 1ns/1ps
module amostra_feeder #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 12,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    amostra_feeder_if.slave          s_in,
    input  logic                     period_end,
    output logic [OUT_W-1:0]         amostra,
    output logic                     amostra_stb,
    output logic                     underrun,
    input  logic                     clr_underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [OUT_W-1:0] SILENCE   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_PRIME = LW'(PRIME_LVL);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IN_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic [OUT_W-1:0]  r_amostra;
    logic              r_stb;
    logic              r_underrun;

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_load_head;
    logic              w_load_mid;
    logic              w_set_under;
    logic [IN_W-1:0]   w_head;
    logic [OUT_W-1:0]  w_conv;

    assign w_in_ready    = (r_level < LVL_FULL);
    assign w_push        = s_in.in_valid && w_in_ready;
    assign s_in.in_ready = w_in_ready;

    // Offset binary: flip the sign bit, keep the top OUT_W-1 magnitude bits.
    assign w_head = r_mem[r_rptr];
    assign w_conv = {~w_head[IN_W-1], w_head[IN_W-2 -: OUT_W-1]};

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load_head  = 1'b0;
        w_load_mid   = 1'b0;
        w_set_under  = 1'b0;
        case (r_state)
            ST_PRIME: begin
                if (period_end) w_load_mid = 1'b1;
                if (r_level >= LVL_PRIME) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (period_end) begin
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_load_head = 1'b1;
                    end else begin
                        w_load_mid   = 1'b1;
                        w_set_under  = 1'b1;
                        w_next_state = ST_PRIME;
                    end
                end
            end
            default: w_next_state = ST_PRIME;
        endcase
    end

    // Sample storage carries no reset; validity is tracked by level/pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= s_in.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_PRIME;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_amostra  <= SILENCE;
            r_stb      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            r_stb   <= w_load_head || w_load_mid;
            if (w_load_head)     r_amostra <= w_conv;
            else if (w_load_mid) r_amostra <= SILENCE;
            if (w_set_under)       r_underrun <= 1'b1;
            else if (clr_underrun) r_underrun <= 1'b0;
        end
    end

    assign amostra     = r_amostra;
    assign amostra_stb = r_stb;
    assign underrun    = r_underrun;
    assign level       = r_level;
endmodule

// File: tb/tb_amostra_feeder.sv
// tb/tb_amostra_feeder.sv - directed self-checking bench for amostra_feeder
`timescale 1ns/1ps
module tb_amostra_feeder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        period_end;
    logic        clr_underrun;
    logic [11:0] amostra;
    logic        amostra_stb;
    logic        underrun;
    logic [4:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    amostra_feeder_if #(.IN_W(16)) u_if ();

    amostra_feeder #(
        .IN_W(16), .OUT_W(12), .DEPTH(16), .PRIME_LVL(8)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_in         (u_if.slave),
        .period_end   (period_end),
        .amostra      (amostra),
        .amostra_stb  (amostra_stb),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] d);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        tick();
        u_if.in_valid = 1'b0;
    endtask

    task automatic pe_check(input string tag, input logic [11:0] exp_a, input int exp_lvl);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check_eq({tag, "_stb"}, 32'(amostra_stb), 32'd1);
        check_eq({tag, "_amostra"}, 32'(amostra), 32'(exp_a));
        check_eq({tag, "_level"}, 32'(level), 32'(exp_lvl));
    endtask

    logic [15:0] prime_vals [8] = '{16'h1230, 16'h8000, 16'h7FFF, 16'h0000,
                                    16'hFFFF, 16'h4000, 16'hC000, 16'h0010};
    logic [11:0] prime_exp  [8] = '{12'h923, 12'h000, 12'hFFF, 12'h800,
                                    12'h7FF, 12'hC00, 12'h400, 12'h801};

    int  src_k;
    int  n_stb;
    bit  gen_done;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; period_end = 1'b0; clr_underrun = 1'b0;
        u_if.in_valid = 1'b0; u_if.in_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_amostra", 32'(amostra), 32'h800);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_stb", 32'(amostra_stb), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(u_if.in_ready), 32'd1);

        // Priming: silence until PRIME_LVL reached, no pops
        for (int i = 0; i < 7; i++) push(prime_vals[i]);
        check_eq("prime_level7", 32'(level), 32'd7);
        for (int i = 0; i < 3; i++) pe_check("prime_pe", 12'h800, 7);
        push(prime_vals[7]);
        check_eq("prime_level8", 32'(level), 32'd8);
        tick();
        for (int i = 0; i < 8; i++) begin
            pe_check("conv", prime_exp[i], 7 - i);
            if (i == 0) begin
                tick();
                check_eq("stb_single", 32'(amostra_stb), 32'd0);
                check_eq("amostra_held", 32'(amostra), 32'h923);
            end
        end
        check_eq("no_underrun_yet", 32'(underrun), 32'd0);

        // Underrun with a simultaneous push that must be stored
        period_end = 1'b1; u_if.in_valid = 1'b1; u_if.in_data = 16'h5550;
        tick();
        period_end = 1'b0; u_if.in_valid = 1'b0;
        check_eq("ur_stb", 32'(amostra_stb), 32'd1);
        check_eq("ur_amostra", 32'(amostra), 32'h800);
        check_eq("ur_flag", 32'(underrun), 32'd1);
        check_eq("ur_push_kept", 32'(level), 32'd1);
        pe_check("ur_back_prime", 12'h800, 1);
        check_eq("ur_sticky", 32'(underrun), 32'd1);
        clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
        check_eq("ur_cleared", 32'(underrun), 32'd0);

        for (int i = 0; i < 7; i++) push(16'h0000);
        tick();
        pe_check("ur2_head", 12'hD55, 7);
        for (int j = 0; j < 7; j++) pe_check("ur2_drain", 12'h800, 6 - j);
        period_end = 1'b1; clr_underrun = 1'b1;
        tick();
        period_end = 1'b0; clr_underrun = 1'b0;
        check_eq("ur_set_beats_clr", 32'(underrun), 32'd1);
        clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
        check_eq("ur_cleared2", 32'(underrun), 32'd0);

        // Full FIFO, dropped write, reopen, push+pop same cycle, pointer wrap
        for (int i = 0; i < 16; i++) push(16'((i + 1) << 4));
        check_eq("full_level", 32'(level), 32'd16);
        check_eq("full_in_ready", 32'(u_if.in_ready), 32'd0);
        push(16'hAAAA);
        check_eq("full_drop_level", 32'(level), 32'd16);
        pe_check("full_pop", 12'h801, 15);
        check_eq("full_reopen", 32'(u_if.in_ready), 32'd1);
        period_end = 1'b1; u_if.in_valid = 1'b1; u_if.in_data = 16'h0110;
        tick();
        period_end = 1'b0; u_if.in_valid = 1'b0;
        check_eq("pushpop_level", 32'(level), 32'd15);
        check_eq("pushpop_amostra", 32'(amostra), 32'h802);
        for (int j = 3; j <= 16; j++) pe_check("full_drain", 12'(12'h800 | j), 17 - j);
        pe_check("full_last", 12'h811, 0);
        pe_check("full_ur", 12'h800, 0);
        check_eq("full_ur_flag", 32'(underrun), 32'd1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push(16'h1000);
        pe_check("pre_rst", 12'h800, 3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_amostra", 32'(amostra), 32'h800);
        check_eq("async_rst_level", 32'(level), 32'd0);
        check_eq("async_rst_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", 32'(u_if.in_ready), 32'd1);
        pe_check("post_rst_prime", 12'h800, 0);
        check_eq("post_rst_no_ur", 32'(underrun), 32'd0);

        // Long run: ramp streamed against a periodic period_end
        src_k = 0; n_stb = 0; gen_done = 1'b0;
        fork
            begin : source
                int guard = 0;
                bit acc;
                while (src_k < 512 && guard < 20000) begin
                    @(negedge clk);
                    u_if.in_valid = 1'b1;
                    u_if.in_data  = 16'(src_k * 128 + 32768);
                    acc = u_if.in_ready;
                    @(posedge clk);
                    if (acc) src_k++;
                    guard++;
                end
                @(negedge clk);
                u_if.in_valid = 1'b0;
            end
            begin : generator
                repeat (40) tick();
                for (int k = 0; k < 512; k++) begin
                    period_end = 1'b1;
                    tick();
                    period_end = 1'b0;
                    check_eq("ramp_amostra", 32'(amostra), 32'(k * 8));
                    repeat (15) tick();
                end
                gen_done = 1'b1;
            end
            begin : monitor
                while (!gen_done) begin
                    @(negedge clk);
                    if (amostra_stb) n_stb++;
                end
            end
        join
        check_eq("ramp_src_done", 32'(src_k), 32'd512);
        check_eq("ramp_stb_count", 32'(n_stb), 32'd512);
        check_eq("ramp_no_underrun", 32'(underrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
